// File: rtl/fetch_npc.sv
// Instruction fetch and next-PC selection.
// Four-state fetch sequencer (IDLE, REQ, HOLD, TRAP) that requests the word at pc,
// registers it, and advances pc from one of four sources.
// Optional feature: define FETCH_MISALIGN_TRAP_EN to trap on a misaligned next PC.
// When it is undefined, the low two bits of the next PC are cleared instead.
module fetch_npc #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] expand_imm,
  input  logic [25:0] jump_index,
  input  logic [31:0] reg_target,
  input  logic [1:0]  npc_sel,
  input  logic        branch_taken,
  input  logic        pc_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misalign
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    TRAP
  } state_t;

  state_t      state, next_state;
  logic [31:0] npc_raw;
  logic [31:0] npc;
  logic        npc_misaligned;

  assign pc_plus4  = pc + 32'd4;
  assign imem_req  = (state == REQ);
  assign imem_addr = pc;

  // Select the raw next PC; all sums wrap modulo 2^32
  always_comb begin
    npc_raw = pc_plus4;
    case (npc_sel)
      2'b00: npc_raw = pc_plus4;
      2'b01: npc_raw = branch_taken ? (pc_plus4 + (expand_imm << 2)) : pc_plus4;
      2'b10: npc_raw = {pc_plus4[31:28], jump_index, 2'b00};
      2'b11: npc_raw = reg_target;
      default: npc_raw = pc_plus4;
    endcase
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  assign npc            = npc_raw;
  assign npc_misaligned = |npc_raw[1:0];
  assign misalign       = (state == TRAP);
`else
  assign npc            = npc_raw & ~32'h0000_0003;
  assign npc_misaligned = 1'b0;
  assign misalign       = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: REQ waits for memory, HOLD waits for retirement
  always_comb begin
    next_state = state;
    case (state)
      IDLE: next_state = REQ;
      REQ:  if (imem_ready) next_state = HOLD;
      HOLD: if (pc_en) next_state = npc_misaligned ? TRAP : REQ;
      TRAP: next_state = TRAP;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: capture fetched word in REQ, advance pc in HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        REQ: begin
          if (imem_ready) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (pc_en) begin
            pc          <= npc;
            instr_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fetch_npc.md
FETCH_NPC -- requirements
Module: fetch_npc

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000: first fetch address after reset.
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 expand_imm  in  32  extended 16-bit immediate from immediate-extension stage (branch offset, words).
REQ-005 jump_index  in  26  J-type target field.
REQ-006 reg_target  in  32  register jump target.
REQ-007 npc_sel  in  2  00 sequential, 01 branch, 10 jump, 11 register.
REQ-008 branch_taken  in  1  branch condition; meaningful only when npc_sel=01.
REQ-009 pc_en  in  1  core retires current instruction; advance PC.
REQ-010 imem_req  out  1  instruction memory request.
REQ-011 imem_addr  out  32  request address (equals pc).
REQ-012 imem_ready  in  1  memory data valid this cycle.
REQ-013 imem_rdata  in  32  memory read data.
REQ-014 instr  out  32  registered fetched instruction.
REQ-015 instr_valid  out  1  instr holds the word at pc.
REQ-016 pc  out  32  current PC; pc_plus4  out  32  pc+4 (combinational).
REQ-017 misalign  out  1  misaligned-target flag (see Configuration).

Function
REQ-018 FSM states SHALL be IDLE, REQ, HOLD, TRAP; encoding free.
REQ-019 IDLE -> REQ unconditionally on the first clock edge after reset release.
REQ-020 In REQ: imem_req=1, imem_addr=pc held stable until imem_ready sampled 1.
REQ-021 REQ with imem_ready=1: instr<=imem_rdata, instr_valid<=1, -> HOLD; zero-wait memory yields one fetch per cycle pair (REQ, HOLD).
REQ-022 In HOLD: imem_req=0; instr/instr_valid stable until pc_en=1.
REQ-023 HOLD with pc_en=1: pc<=npc, instr_valid<=0, -> REQ.
REQ-024 pc_en outside HOLD, imem_ready outside REQ: ignored, no state change.
REQ-025 npc: 00 -> pc+4; 01 -> branch_taken ? pc+4+(expand_imm<<2) : pc+4; 10 -> {pc_plus4[31:28], jump_index, 2'b00}; 11 -> reg_target.
REQ-026 All PC arithmetic 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0; shifted offset bits above 31 discarded.
REQ-027 Negative expand_imm SHALL move PC backwards (two's complement add).

Reset
REQ-028 rst_n=0 immediately forces: state IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, misalign=0.
REQ-029 Reset mid-request aborts the request; imem_ready during reset ignored; fetch restarts at RESET_PC.

Configuration
REQ-030 Macro FETCH_MISALIGN_TRAP_EN.
REQ-031 Defined: selected npc with npc[1:0]!=0 at a HOLD advance -> pc<=npc, state TRAP, misalign=1, imem_req=0; TRAP exits only by reset.
REQ-032 Undefined: npc[1:0] forced to 2'b00 before loading pc; TRAP unreachable; misalign tied 0.

Verification
REQ-033 Reset release, imem_ready=1 always, pc_en=1 always -> imem_addr 0x3000, 0x3004, 0x3008 on successive REQ cycles; instr_valid pulses every 2nd cycle.
REQ-034 pc=0x3010, npc_sel=01, branch_taken=1, expand_imm=0xFFFF_FFFE -> next imem_addr 0x300C; branch_taken=0 -> 0x3014.
REQ-035 pc=0x3000, npc_sel=10, jump_index=26'h000_0C10 -> next pc 0x0000_3040; npc_sel=11, reg_target=0x0000_4000 -> 0x4000.
REQ-036 imem_ready low 3 cycles in REQ -> imem_req and imem_addr stable 4 cycles, instr captured on 4th; pc_en=1 during wait -> no change.
REQ-037 rst_n low for 1 cycle mid-REQ at pc=0x3020 -> imem_req drops immediately, restart at 0x3000, instr_valid=0.
REQ-038 npc_sel=11, reg_target=0x0000_4002: with FETCH_MISALIGN_TRAP_EN -> misalign=1, imem_req stays 0; without -> next imem_addr 0x4000, misalign=0.
